// File: rtl/pwm_ramp_sequencer.sv
// PWM compare-register ramp engine: steps a bus-written value from start to end once per PWM period IRQ.
// Optional build macro PWM_SEQ_TIMEOUT_EN adds a busy-stall timeout and the timeout_error output.
module pwm_ramp_sequencer #(
    parameter int WIDTH = 16
`ifdef PWM_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic [23:0]      target_address,
    input  logic [WIDTH-1:0] start_value,
    input  logic [WIDTH-1:0] end_value,
    input  logic [WIDTH-1:0] step,
    input  logic             trigger,
    output logic             bus_request,
    input  logic             bus_grant,
    output logic             peripheralBus_we,
    output logic             peripheralBus_oe,
    input  logic             peripheralBus_busy,
    output logic [23:0]      peripheralBus_address,
    output logic [3:0]       peripheralBus_byteSelect,
    output logic [31:0]      peripheralBus_dataWrite,
    output logic [WIDTH-1:0] current_value,
    output logic             done,
    output logic             overrun
`ifdef PWM_SEQ_TIMEOUT_EN
    , output logic           timeout_error
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_WRITE,
        ST_WAIT_TRIGGER,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] current_value_reg, current_value_next;
    logic             dir_up_reg, dir_up_next;
    logic             pending_reg, pending_next;
    logic             overrun_reg, overrun_next;
    logic             trigger_reg, trigger_q_reg;
    logic             trigger_edge;
    logic             consume;

`ifdef PWM_SEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_count_reg, stall_count_next;
    logic               timeout_error_reg, timeout_error_next;
    logic               start_allowed;
    assign start_allowed = ~timeout_error_reg;
`else
    logic               start_allowed;
    assign start_allowed = 1'b1;
`endif

    // Next-value datapath
    logic             base_up;
    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] leg_target;
    logic             turn;
    logic             dir_eff;
    logic [WIDTH-1:0] target_eff;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] next_value;

    // The rising edge is taken between two registered copies, so a raw IRQ level is never used directly.
    assign trigger_edge = trigger_reg & ~trigger_q_reg;

    always_comb begin
        base_up    = (end_value >= start_value);
        step_eff   = (step == '0) ? WIDTH'(1) : step;
        // Current leg heads to end_value while dir matches the base direction, else back to start_value.
        leg_target = (dir_up_reg == base_up) ? end_value : start_value;
        turn       = mode & (current_value_reg == leg_target);
        dir_eff    = turn ? ~dir_up_reg : dir_up_reg;
        target_eff = (dir_eff == base_up) ? end_value : start_value;
        sum_ext    = {1'b0, current_value_reg} + {1'b0, step_eff};
        diff_ext   = {1'b0, current_value_reg} - {1'b0, step_eff};
        next_value = current_value_reg;
        if (dir_eff) begin
            next_value = (sum_ext > {1'b0, target_eff}) ? target_eff : sum_ext[WIDTH-1:0];
        end else begin
            next_value = (diff_ext[WIDTH] || (diff_ext[WIDTH-1:0] < target_eff))
                         ? target_eff : diff_ext[WIDTH-1:0];
        end
    end

    always_comb begin
        state_next         = state_reg;
        current_value_next = current_value_reg;
        dir_up_next        = dir_up_reg;
        pending_next       = pending_reg;
        overrun_next       = overrun_reg;
        consume            = 1'b0;
`ifdef PWM_SEQ_TIMEOUT_EN
        stall_count_next   = stall_count_reg;
        timeout_error_next = timeout_error_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                pending_next = 1'b0;
                overrun_next = 1'b0;
`ifdef PWM_SEQ_TIMEOUT_EN
                if (!enable) begin
                    timeout_error_next = 1'b0;
                end
`endif
                if (enable && start_allowed) begin
                    current_value_next = start_value;
                    dir_up_next        = base_up;
                    state_next         = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (bus_grant) begin
                    state_next = ST_WRITE;
`ifdef PWM_SEQ_TIMEOUT_EN
                    stall_count_next = '0;
`endif
                end
            end
            ST_WRITE: begin
                if (!peripheralBus_busy) begin
                    if (!mode && (current_value_reg == end_value)) begin
                        state_next = ST_DONE;
                    end else if (!enable) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT_TRIGGER;
                    end
                end
`ifdef PWM_SEQ_TIMEOUT_EN
                else if (stall_count_reg == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the write; IDLE holds off restart until enable is cycled.
                    timeout_error_next = 1'b1;
                    state_next         = ST_IDLE;
                end else begin
                    stall_count_next = stall_count_reg + 1'b1;
                end
`endif
            end
            ST_WAIT_TRIGGER: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (pending_reg) begin
                    consume            = 1'b1;
                    pending_next       = 1'b0;
                    current_value_next = next_value;
                    dir_up_next        = dir_eff;
                    state_next         = ST_REQUEST;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A second edge before the first is consumed is dropped and flagged.
        if (trigger_edge && (state_reg != ST_IDLE)) begin
            if (pending_reg && !consume) begin
                overrun_next = 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            current_value_reg <= '0;
            dir_up_reg        <= 1'b0;
            pending_reg       <= 1'b0;
            overrun_reg       <= 1'b0;
            trigger_reg       <= 1'b0;
            trigger_q_reg     <= 1'b0;
`ifdef PWM_SEQ_TIMEOUT_EN
            stall_count_reg   <= '0;
            timeout_error_reg <= 1'b0;
`endif
        end else begin
            state_reg         <= state_next;
            current_value_reg <= current_value_next;
            dir_up_reg        <= dir_up_next;
            pending_reg       <= pending_next;
            overrun_reg       <= overrun_next;
            trigger_reg       <= trigger;
            trigger_q_reg     <= trigger_reg;
`ifdef PWM_SEQ_TIMEOUT_EN
            stall_count_reg   <= stall_count_next;
            timeout_error_reg <= timeout_error_next;
`endif
        end
    end

    logic [31:0] data_ext;
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_data_ext
            if (gi < WIDTH) begin : g_bit
                assign data_ext[gi] = current_value_reg[gi];
            end else begin : g_zero
                assign data_ext[gi] = 1'b0;
            end
        end
    endgenerate

    logic writing;
    assign writing = (state_reg == ST_WRITE);

    assign bus_request              = (state_reg == ST_REQUEST) || writing;
    assign peripheralBus_we         = writing;
    assign peripheralBus_oe         = 1'b0;
    assign peripheralBus_address    = writing ? target_address : 24'h0;
    assign peripheralBus_byteSelect = writing ? 4'b0011 : 4'b0000;
    assign peripheralBus_dataWrite  = writing ? data_ext : 32'h0;
    assign current_value            = current_value_reg;
    assign done                     = (state_reg == ST_DONE);
    assign overrun                  = overrun_reg;
`ifdef PWM_SEQ_TIMEOUT_EN
    assign timeout_error            = timeout_error_reg;
`endif

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: ramps, clamping, triangle, handshake, overrun and write abort.
module tb_pwm_ramp_sequencer;
    localparam int WIDTH = 16;
    localparam logic [23:0] ADDR = 24'hA51230;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             mode;
    logic [23:0]      target_address;
    logic [WIDTH-1:0] start_value;
    logic [WIDTH-1:0] end_value;
    logic [WIDTH-1:0] step;
    logic             trigger;
    logic             bus_request;
    logic             bus_grant;
    logic             peripheralBus_we;
    logic             peripheralBus_oe;
    logic             peripheralBus_busy;
    logic [23:0]      peripheralBus_address;
    logic [3:0]       peripheralBus_byteSelect;
    logic [31:0]      peripheralBus_dataWrite;
    logic [WIDTH-1:0] current_value;
    logic             done;
    logic             overrun;
`ifdef PWM_SEQ_TIMEOUT_EN
    logic             timeout_error;
`endif

    always #5 clk = ~clk;

    pwm_ramp_sequencer #(
        .WIDTH(WIDTH)
`ifdef PWM_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mode(mode),
        .target_address(target_address),
        .start_value(start_value),
        .end_value(end_value),
        .step(step),
        .trigger(trigger),
        .bus_request(bus_request),
        .bus_grant(bus_grant),
        .peripheralBus_we(peripheralBus_we),
        .peripheralBus_oe(peripheralBus_oe),
        .peripheralBus_busy(peripheralBus_busy),
        .peripheralBus_address(peripheralBus_address),
        .peripheralBus_byteSelect(peripheralBus_byteSelect),
        .peripheralBus_dataWrite(peripheralBus_dataWrite),
        .current_value(current_value),
        .done(done),
        .overrun(overrun)
`ifdef PWM_SEQ_TIMEOUT_EN
        , .timeout_error(timeout_error)
`endif
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] wr_data_q[$];
    logic [23:0] wr_addr_q[$];
    logic [3:0]  wr_bs_q[$];
    logic [31:0] exp_q[$];

    // A write completes at the next rising edge when we is high and busy is low.
    always @(negedge clk) begin
        if (!rst && peripheralBus_we && !peripheralBus_busy) begin
            wr_data_q.push_back(peripheralBus_dataWrite);
            wr_addr_q.push_back(peripheralBus_address);
            wr_bs_q.push_back(peripheralBus_byteSelect);
            $display("write addr=0x%06h be=%b data=0x%08h", peripheralBus_address,
                     peripheralBus_byteSelect, peripheralBus_dataWrite);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        check($sformatf("%s_count", tag), 32'(wr_data_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_data_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_q[i]);
                check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(ADDR));
                check($sformatf("%s_be%0d", tag, i), 32'(wr_bs_q[i]), 32'h3);
            end
        end
        wr_data_q.delete();
        wr_addr_q.delete();
        wr_bs_q.delete();
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick(3);
        trigger = 1'b0;
        tick(7);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 1'b0; target_address = ADDR;
        start_value = '0; end_value = '0; step = '0; trigger = 1'b0;
        bus_grant = 1'b1; peripheralBus_busy = 1'b0;
        tick(3);
        check("rst_req", 32'(bus_request), 32'h0);
        check("rst_we", 32'(peripheralBus_we), 32'h0);
        check("rst_oe", 32'(peripheralBus_oe), 32'h0);
        check("rst_data", peripheralBus_dataWrite, 32'h0);
        check("rst_be", 32'(peripheralBus_byteSelect), 32'h0);
        check("rst_cur", 32'(current_value), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        rst = 1'b0;
        tick(1);

        // One-shot up ramp; enable-to-strobe and trigger-to-strobe latency measured exactly.
        start_value = 16'h0010; end_value = 16'h0040; step = 16'h0010;
        enable = 1'b1;
        tick(1);
        check("up_req_c1", 32'(bus_request), 32'h1);
        check("up_we_c1", 32'(peripheralBus_we), 32'h0);
        tick(1);
        check("up_we_c2", 32'(peripheralBus_we), 32'h1);
        check("up_data_c2", peripheralBus_dataWrite, 32'h10);
        check("up_addr_c2", 32'(peripheralBus_address), 32'(ADDR));
        tick(1);
        check("up_we_c3", 32'(peripheralBus_we), 32'h0);
        check("up_req_c3", 32'(bus_request), 32'h0);
        tick(2);
        trigger = 1'b1;
        tick(3);
        check("trg_we_c3", 32'(peripheralBus_we), 32'h0);
        check("trg_req_c3", 32'(bus_request), 32'h1);
        check("trg_cur_c3", 32'(current_value), 32'h20);
        tick(1);
        check("trg_we_c4", 32'(peripheralBus_we), 32'h1);
        check("trg_data_c4", peripheralBus_dataWrite, 32'h20);
        trigger = 1'b0;
        tick(6);
        repeat (4) pulse_trigger();
        exp_q = '{32'h10, 32'h20, 32'h30, 32'h40};
        check_writes("up");
        check("up_done", 32'(done), 32'h1);
        check("up_cur", 32'(current_value), 32'h40);
        enable = 1'b0;
        tick(2);
        check("up_done_clr", 32'(done), 32'h0);
        check("up_ovr_clr", 32'(overrun), 32'h0);

        // Downward ramp clamps at end_value instead of wrapping below zero.
        start_value = 16'h0005; end_value = 16'h0000; step = 16'h0003;
        enable = 1'b1;
        tick(5);
        repeat (3) pulse_trigger();
        exp_q = '{32'h5, 32'h2, 32'h0};
        check_writes("down");
        check("down_done", 32'(done), 32'h1);
        enable = 1'b0;
        tick(2);

        // Triangle with step 0, which behaves as step 1: 1,2,3,2,1,2,3.
        mode = 1'b1; start_value = 16'h0001; end_value = 16'h0003; step = 16'h0000;
        enable = 1'b1;
        tick(5);
        repeat (6) pulse_trigger();
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h2, 32'h1, 32'h2, 32'h3};
        check_writes("tri");
        check("tri_done", 32'(done), 32'h0);
        enable = 1'b0;
        tick(2);
        mode = 1'b0;

        // Grant withheld 10 cycles, then busy for 3 cycles of the write.
        bus_grant = 1'b0; start_value = 16'h1234; end_value = 16'h1234; step = 16'h0001;
        enable = 1'b1;
        tick(10);
        check("hs_we_nogrant", 32'(peripheralBus_we), 32'h0);
        check("hs_req_nogrant", 32'(bus_request), 32'h1);
        bus_grant = 1'b1; peripheralBus_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            check($sformatf("hs_we%0d", c), 32'(peripheralBus_we), 32'h1);
            check($sformatf("hs_data%0d", c), peripheralBus_dataWrite, 32'h1234);
            check($sformatf("hs_addr%0d", c), 32'(peripheralBus_address), 32'(ADDR));
        end
        peripheralBus_busy = 1'b0;
        tick(1);
        check("hs_we_end", 32'(peripheralBus_we), 32'h0);
        check("hs_done", 32'(done), 32'h1);
        exp_q = '{32'h1234};
        check_writes("hs");
        enable = 1'b0;
        tick(2);

        // Two edges while stuck in REQUEST: second is dropped and flagged.
        bus_grant = 1'b0; start_value = 16'h0100; end_value = 16'h0500; step = 16'h0100;
        enable = 1'b1;
        tick(2);
        trigger = 1'b1; tick(2); trigger = 1'b0; tick(2);
        trigger = 1'b1; tick(2); trigger = 1'b0; tick(3);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_we", 32'(peripheralBus_we), 32'h0);
        bus_grant = 1'b1;
        tick(10);
        check("ovr_cur", 32'(current_value), 32'h200);
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Dropping enable mid-write lets the write finish, then returns to IDLE.
        peripheralBus_busy = 1'b1;
        trigger = 1'b1;
        tick(6);
        trigger = 1'b0;
        check("abt_we", 32'(peripheralBus_we), 32'h1);
        check("abt_data", peripheralBus_dataWrite, 32'h300);
        enable = 1'b0;
        tick(3);
        check("abt_we_held", 32'(peripheralBus_we), 32'h1);
        peripheralBus_busy = 1'b0;
        tick(1);
        check("abt_we_end", 32'(peripheralBus_we), 32'h0);
        tick(1);
        check("abt_done", 32'(done), 32'h0);
        check("abt_ovr", 32'(overrun), 32'h0);
        check("abt_req", 32'(bus_request), 32'h0);
        check("abt_cur", 32'(current_value), 32'h300);
        exp_q = '{32'h100, 32'h200, 32'h300};
        check_writes("ovr");

`ifdef PWM_SEQ_TIMEOUT_EN
        // Busy stuck high: strobe lasts exactly 8 cycles, then IDLE with timeout latched.
        begin
            int we_cycles;
            we_cycles = 0;
            start_value = 16'h0007; end_value = 16'h0009; step = 16'h0001;
            peripheralBus_busy = 1'b1;
            enable = 1'b1;
            repeat (14) begin
                tick(1);
                if (peripheralBus_we) we_cycles++;
            end
            check("to_we_cycles", 32'(we_cycles), 32'd8);
            check("to_err", 32'(timeout_error), 32'h1);
            check("to_req", 32'(bus_request), 32'h0);
            peripheralBus_busy = 1'b0;
            tick(4);
            check("to_no_restart", 32'(peripheralBus_we | bus_request), 32'h0);
            enable = 1'b0;
            tick(2);
            check("to_err_clr", 32'(timeout_error), 32'h0);
            wr_data_q.delete();
            wr_addr_q.delete();
            wr_bs_q.delete();
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
